// File: rtl/trivia_mem_reader.sv
// trivia_mem_reader
//   Avalon-MM read master: fetches cmd_len consecutive 32-bit words starting at
//   cmd_addr and streams them in order on a valid/ready interface. Read issue
//   is credit-limited so the return FIFO can never overflow.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   cmd_start/addr/len  command (accepted only while idle)
//   cmd_abort           stop the running transfer early
//   busy, done, aborted status; done is a one-cycle pulse, aborted qualifies it
//   avm_*               Avalon-MM read master (fixed READ_LATENCY)
//   out_valid/data/last/ready  return stream
//   checksum            (TRIVIA_MEM_READER_CHECKSUM_EN only) sum of popped words
module trivia_mem_reader #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 15,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
`ifdef TRIVIA_MEM_READER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_count, inflight;
  logic [LEN_W-1:0]      remaining;
  logic [READ_LATENCY:1] vld_pipe;

  logic          accepted, push_tag, push, pop, final_pop, flush, issue_nxt;
  logic [LEN_W-1:0] rem_nxt;
  logic [CW:0]   used_nxt;

  assign avm_byteenable = 4'hF;
  assign busy      = (state != IDLE);
  assign accepted  = avm_read & ~avm_waitrequest;
  assign push_tag  = vld_pipe[READ_LATENCY];
  // returning data is dropped while draining an aborted transfer
  assign push      = push_tag && (state == RUN);
  assign out_valid = (fifo_count != '0) && (state == RUN);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (remaining == '0) && (inflight == '0) &&
                     (fifo_count == CW'(1));
  assign pop       = out_valid & out_ready;
  assign final_pop = pop & out_last;
  // completion wins over an abort arriving on the same cycle
  assign flush     = (state == DRAIN) || ((state == RUN) && cmd_abort && !final_pop);

  // Credits: FIFO occupancy plus reads still in the latency pipe, as they will
  // stand after this edge. A push moves a word from inflight to the FIFO and
  // leaves the sum unchanged, so only accept and pop matter.
  assign rem_nxt   = remaining - LEN_W'(accepted);
  assign used_nxt  = {1'b0, fifo_count} + {1'b0, inflight} + (CW+1)'(accepted)
                     - (CW+1)'(pop);
  assign issue_nxt = (rem_nxt != '0) && (used_nxt < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_start && cmd_len != '0) state_nxt = RUN;
      RUN:     if (final_pop) state_nxt = IDLE;
               else if (cmd_abort) state_nxt = DRAIN;
      DRAIN:   if (inflight == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= '0;
      remaining   <= '0;
      inflight    <= '0;
      vld_pipe    <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      done        <= 1'b0;
      vld_pipe[1] <= accepted;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      inflight    <= inflight + CW'(accepted) - CW'(push_tag);

      case (state)
        IDLE: if (cmd_start) begin
          aborted <= 1'b0;
          if (cmd_len == '0) begin
            done <= 1'b1;
          end else begin
            avm_address <= cmd_addr;
            remaining   <= cmd_len;
            avm_read    <= 1'b1;
          end
        end
        RUN: begin
          if (accepted) begin
            avm_address <= avm_address + 1'b1;
            remaining   <= remaining - 1'b1;
          end
          if (final_pop) begin
            done     <= 1'b1;
            avm_read <= 1'b0;
          end else if (cmd_abort) begin
            avm_read <= 1'b0;
          end else if (!(avm_read && avm_waitrequest)) begin
            avm_read <= issue_nxt;
          end
        end
        DRAIN: if (inflight == '0) begin
          done    <= 1'b1;
          aborted <= 1'b1;
        end
        default: ;
      endcase

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= avm_readdata;
  end

`ifdef TRIVIA_MEM_READER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset)                          checksum <= '0;
    else if (state == IDLE && cmd_start) checksum <= '0;
    else if (pop)                       checksum <= checksum + out_data;
  end
`endif

  // the credit check must keep every push inside the FIFO
  always @(posedge clk) begin
    if (!reset) assert (!(push && fifo_count == CW'(FIFO_DEPTH)));
  end

endmodule

// File: tb/tb_trivia_mem_reader.sv
// Directed bench for trivia_mem_reader: memory model mem[i]=0xA000_0000+i,
// expected words/addresses queued at command time and popped as the DUT
// accepts reads and pops stream words.
module tb_trivia_mem_reader;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_start = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              cmd_abort = 1'b0;
  logic              busy, done, aborted;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest = 1'b0;
  logic [DATA_W-1:0] avm_readdata = '0;
  logic              out_valid, out_last;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
`ifdef TRIVIA_MEM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  always #5 clk = ~clk;

  trivia_mem_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                      .READ_LATENCY(1), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_abort(cmd_abort),
    .busy(busy), .done(done), .aborted(aborted),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
`ifdef TRIVIA_MEM_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + {17'b0, a};
  endfunction

  // latency-1 memory slave
  always @(posedge clk)
    if (avm_read === 1'b1 && avm_waitrequest === 1'b0)
      avm_readdata <= mem_word(avm_address);

  int n_pass = 0, n_tot = 0;
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int  n_reads = 0, n_pops = 0, done_cnt = 0, cyc = 0;
  int  last_pop_cyc = 0, done_cyc = 0, first_rd_cyc = 0, last_rd_cyc = 0;
  logic last_aborted = 1'b0;
  bit   ws_mode = 1'b0;
  logic [31:0] cs_model = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: observe the handshakes about to complete, advance, sample.
  task automatic step();
    logic hold;
    logic [ADDR_W-1:0] haddr;
    logic [31:0] e;
    hold = 1'b0;
    haddr = '0;
    if (avm_read === 1'b1 && avm_waitrequest === 1'b0) begin
      if (n_reads == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      n_reads++;
      chk("rd_expected", 64'(exp_addr_q.size() != 0), 1);
      if (exp_addr_q.size() != 0) chk("rd_addr", avm_address, exp_addr_q.pop_front());
    end
    if (ws_mode && avm_read === 1'b1 && avm_waitrequest === 1'b1) begin
      hold = 1'b1;
      haddr = avm_address;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      n_pops++;
      last_pop_cyc = cyc;
      chk("word_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chk("last", out_last, 64'(exp_q.size() == 1));
        e = exp_q.pop_front();
        cs_model += e;
        chk("data", out_data, e);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      last_aborted = aborted;
    end
    if (hold) begin
      chk("ws_hold_read", avm_read, 1);
      chk("ws_hold_addr", avm_address, haddr);
    end
    if (ws_mode) avm_waitrequest = ~avm_waitrequest;
  endtask

  task automatic start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
    logic [ADDR_W-1:0] ai;
    for (int i = 0; i < int'(n); i++) begin
      ai = a + ADDR_W'(i);
      exp_q.push_back(mem_word(ai));
      exp_addr_q.push_back(ai);
    end
    cs_model = '0;
    n_reads = 0;
    cmd_addr = a;
    cmd_len = n;
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (done_cnt != d0) got = 1'b1;
    end
    chk(tag, 64'(got), 1);
  endtask

  initial begin
    logic [31:0] hold_data;
    int p0, d0;
    bit got;

    // reset state
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("byteenable", avm_byteenable, 4'hF);
    reset = 1'b0;
    step();

    // basic read
    out_ready = 1'b1;
    start(15'h0010, 4);
    wait_done("t1_done", 40);
    chk("t1_reads", n_reads, 4);
    chk("t1_read_span", last_rd_cyc - first_rd_cyc, 3);
    chk("t1_done_latency", done_cyc - last_pop_cyc, 1);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_aborted", last_aborted, 0);
    chk("t1_all_words", exp_q.size(), 0);
`ifdef TRIVIA_MEM_READER_CHECKSUM_EN
    chk("t1_checksum", checksum, 32'h8000_0046);
`endif
    step();

    // backpressure
    out_ready = 1'b0;
    p0 = n_pops;
    start(15'h0100, 20);
    repeat (4) step();
    hold_data = out_data;
    repeat (26) step();
    chk("t2_reads_capped", n_reads, 8);
    chk("t2_read_low", avm_read, 0);
    chk("t2_valid", out_valid, 1);
    chk("t2_head_early", hold_data, mem_word(15'h0100));
    chk("t2_head_late", out_data, mem_word(15'h0100));
    out_ready = 1'b1;
    wait_done("t2_done", 100);
    chk("t2_pops", n_pops - p0, 20);
    chk("t2_all_words", exp_q.size(), 0);
    chk("t2_aborted", last_aborted, 0);
`ifdef TRIVIA_MEM_READER_CHECKSUM_EN
    chk("t2_checksum", checksum, cs_model);
`endif

    // waitrequest on alternate cycles
    ws_mode = 1'b1;
    avm_waitrequest = 1'b1;
    start(15'h0200, 6);
    wait_done("t3_done", 100);
    ws_mode = 1'b0;
    avm_waitrequest = 1'b0;
    chk("t3_reads", n_reads, 6);
    chk("t3_all_addr", exp_addr_q.size(), 0);
    chk("t3_all_words", exp_q.size(), 0);

    // address wrap, then zero length
    start(15'h7FFE, 3);
    wait_done("t4_done", 40);
    chk("t4_reads", n_reads, 3);
    chk("t4_all_addr", exp_addr_q.size(), 0);
    chk("t4_all_words", exp_q.size(), 0);
    step();
    start(15'h0050, 0);
    chk("t4_zero_done", done, 1);
    chk("t4_zero_aborted", aborted, 0);
    chk("t4_zero_busy", busy, 0);
    step();
    chk("t4_zero_pulse", done, 0);
    repeat (4) step();
    chk("t4_zero_reads", n_reads, 0);

    // abort
    p0 = n_pops;
    start(15'h0300, 100);
    for (int i = 0; i < 200 && (n_pops - p0) < 10; i++) step();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("t5_read_off", avm_read, 0);
    chk("t5_valid_off", out_valid, 0);
    chk("t5_busy", busy, 1);
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (done_cnt != d0) got = 1'b1;
      else chk("t5_drain_valid", out_valid, 0);
    end
    chk("t5_done", 64'(got), 1);
    chk("t5_aborted", last_aborted, 1);
    exp_q.delete();
    exp_addr_q.delete();
    step();
    start(15'h0400, 5);
    wait_done("t5_restart_done", 40);
    chk("t5_restart_aborted", last_aborted, 0);
    chk("t5_restart_reads", n_reads, 5);
    chk("t5_restart_words", exp_q.size(), 0);

    // reset mid-transfer
    out_ready = 1'b0;
    start(15'h0500, 20);
    repeat (6) step();
    chk("t6_pre_valid", out_valid, 1);
    d0 = done_cnt;
    reset = 1'b1;
    step();
    chk("t6_busy", busy, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_last", out_last, 0);
    chk("t6_avm_read", avm_read, 0);
    chk("t6_avm_address", avm_address, 0);
    chk("t6_done", done, 0);
    reset = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (5) step();
    chk("t6_no_done", done_cnt, d0);
    out_ready = 1'b1;
    start(15'h0600, 3);
    wait_done("t6_restart_done", 40);
    chk("t6_restart_reads", n_reads, 3);
    chk("t6_restart_words", exp_q.size(), 0);
    chk("t6_restart_aborted", last_aborted, 0);
`ifdef TRIVIA_MEM_READER_CHECKSUM_EN
    chk("t6_checksum", checksum, cs_model);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
